// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter for one synchronous single-port data RAM; read data returns 1 cycle after accept.
// Optional DMEM_ARB_FIXED_PRIO_EN: port 0 always wins on contention (otherwise round-robin).
module dmem_port_arbiter #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_ready,
  output logic          req0_rvalid,
  output logic [DW-1:0] req0_rdata,
  input  logic          req1_valid,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_ready,
  output logic          req1_rvalid,
  output logic [DW-1:0] req1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  logic gnt0, gnt1;
  logic rsp_pending_q, rsp_pending_d;
  logic rsp_owner_q, rsp_owner_d;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt0 = !reset && req0_valid;
    gnt1 = !reset && req1_valid && !req0_valid;
  end
`else
  logic rr_ptr_q, rr_ptr_d;

  always_comb begin
    gnt0 = !reset && req0_valid && (!req1_valid || !rr_ptr_q);
    gnt1 = !reset && req1_valid && (!req0_valid || rr_ptr_q);
  end

  // After serving a port, prefer the other one next time.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt0)      rr_ptr_d = 1'b1;
    else if (gnt1) rr_ptr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) rr_ptr_q <= 1'b0;
    else       rr_ptr_q <= rr_ptr_d;
  end
`endif

  always_comb begin
    rsp_pending_d = (gnt0 && !req0_we) || (gnt1 && !req1_we);
    rsp_owner_d   = rsp_pending_d ? gnt1 : rsp_owner_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_pending_q <= 1'b0;
      rsp_owner_q   <= 1'b0;
    end else begin
      rsp_pending_q <= rsp_pending_d;
      rsp_owner_q   <= rsp_owner_d;
    end
  end

  always_comb begin
    req0_ready = gnt0;
    req1_ready = gnt1;
    mem_en     = gnt0 || gnt1;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (gnt1) begin
      mem_we    = req1_we;
      mem_addr  = req1_addr;
      mem_wdata = req1_wdata;
    end else if (gnt0) begin
      mem_we    = req0_we;
      mem_addr  = req0_addr;
      mem_wdata = req0_wdata;
    end
  end

  // Response is masked during reset so an in-flight read is dropped immediately.
  always_comb begin
    req0_rvalid = !reset && rsp_pending_q && !rsp_owner_q;
    req1_rvalid = !reset && rsp_pending_q &&  rsp_owner_q;
    req0_rdata  = req0_rvalid ? mem_rdata : '0;
    req1_rdata  = req1_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural synchronous RAM.
module tb_dmem_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req0_we, req0_ready, req0_rvalid;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata, req0_rdata;
  logic          req1_valid, req1_we, req1_ready, req1_rvalid;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata, req1_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  int errors = 0;
  int checks = 0;

  dmem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Unwritten locations read back a fixed address-derived pattern.
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    if (a == 10'h005) return 32'hDEAD_BEEF;
    return 32'hA500_0000 | {22'd0, a};
  endfunction

  logic [DW-1:0] ram    [0:(1<<AW)-1];
  bit            ram_wr [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr]    <= mem_wdata;
        ram_wr[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : pat(mem_addr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic v1, input logic we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    idle();
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 1'b0, 10'h001, '0, 1'b1, 1'b1, 10'h002, 32'h1);
    tick();
    @(negedge clk);
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready0 got=%b exp=0", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready1 got=%b exp=0", req1_ready); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en got=%b exp=0", mem_en); end
    checks++; if ({req0_rvalid, req1_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid got=%b exp=00", {req0_rvalid, req1_rvalid}); end
    tick();
    reset = 1'b0;
    idle();
  endtask

  task automatic test_single_read();
    drive(1'b1, 1'b0, 10'h005, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready0 got=%b exp=1", req0_ready); end
    checks++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 10'h005}) begin
      errors++; $display("FAIL single_mem got en=%b we=%b addr=%h exp en=1 we=0 addr=005", mem_en, mem_we, mem_addr); end
    tick();
    idle();
    @(negedge clk);
    checks++; if (req0_rvalid !== 1'b1) begin errors++; $display("FAIL single_rvalid0 got=%b exp=1", req0_rvalid); end
    checks++; if (req0_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_rdata0 got=%h exp=deadbeef", req0_rdata); end
    checks++; if (req1_rvalid !== 1'b0) begin errors++; $display("FAIL single_rvalid1 got=%b exp=0", req1_rvalid); end
    checks++; if (req1_rdata !== '0) begin errors++; $display("FAIL single_rdata1 got=%h exp=0", req1_rdata); end
    tick();
    @(negedge clk);
    checks++; if (req0_rvalid !== 1'b0) begin errors++; $display("FAIL single_pulse got=%b exp=0", req0_rvalid); end
    tick();
  endtask

  task automatic test_contention();
    logic g, prev;
    apply_reset();
    prev = 1'b0;
    drive(1'b1, 1'b0, 10'h001, '0, 1'b1, 1'b0, 10'h002, '0);
    for (int k = 0; k < 4; k++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      g = 1'b0;
`else
      g = k[0];
`endif
      @(negedge clk);
      checks++; if ({req1_ready, req0_ready} !== {g, ~g}) begin
        errors++; $display("FAIL cont_grant[%0d] got r1r0=%b%b exp=%b%b", k, req1_ready, req0_ready, g, ~g); end
      checks++; if (mem_addr !== (g ? 10'h002 : 10'h001)) begin
        errors++; $display("FAIL cont_addr[%0d] got=%h exp=%h", k, mem_addr, g ? 10'h002 : 10'h001); end
      if (k > 0) begin
        checks++; if ({req1_rvalid, req0_rvalid} !== {prev, ~prev}) begin
          errors++; $display("FAIL cont_rvalid[%0d] got=%b%b exp=%b%b", k, req1_rvalid, req0_rvalid, prev, ~prev); end
        checks++; if ((prev ? req1_rdata : req0_rdata) !== pat(prev ? 10'h002 : 10'h001)) begin
          errors++; $display("FAIL cont_rdata[%0d] got=%h exp=%h", k, prev ? req1_rdata : req0_rdata, pat(prev ? 10'h002 : 10'h001)); end
      end
      prev = g;
      tick();
    end
    idle();
    @(negedge clk);
    checks++; if ({req1_rvalid, req0_rvalid} !== {prev, ~prev}) begin
      errors++; $display("FAIL cont_last_rvalid got=%b%b exp=%b%b", req1_rvalid, req0_rvalid, prev, ~prev); end
    tick();
  endtask

  task automatic test_write_read();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 10'h3FF, 32'h0000_00AA);
    @(negedge clk);
    checks++; if ({req1_ready, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b111, 10'h3FF, 32'h0000_00AA}) begin
      errors++; $display("FAIL wr_issue got rdy=%b en=%b we=%b addr=%h wd=%h exp 1 1 1 3ff 000000aa",
                         req1_ready, mem_en, mem_we, mem_addr, mem_wdata); end
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 10'h3FF, '0);
    @(negedge clk);
    checks++; if ({req0_rvalid, req1_rvalid} !== 2'b00) begin
      errors++; $display("FAIL wr_no_rvalid got=%b exp=00", {req0_rvalid, req1_rvalid}); end
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL wr_rd_ready1 got=%b exp=1", req1_ready); end
    tick();
    idle();
    @(negedge clk);
    checks++; if ({req1_rvalid, req1_rdata} !== {1'b1, 32'h0000_00AA}) begin
      errors++; $display("FAIL wr_rd_data got v=%b d=%h exp v=1 d=000000aa", req1_rvalid, req1_rdata); end
    tick();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b0, 10'h010, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++; if ({mem_en, req0_ready} !== 2'b11) begin errors++; $display("FAIL b2b_c0 got en=%b rdy0=%b exp 11", mem_en, req0_ready); end
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 10'h020, '0);
    @(negedge clk);
    checks++; if ({mem_en, req1_ready, mem_addr} !== {2'b11, 10'h020}) begin
      errors++; $display("FAIL b2b_c1 got en=%b rdy1=%b addr=%h exp 1 1 020", mem_en, req1_ready, mem_addr); end
    checks++; if ({req0_rvalid, req0_rdata} !== {1'b1, pat(10'h010)}) begin
      errors++; $display("FAIL b2b_rsp0 got v=%b d=%h exp v=1 d=%h", req0_rvalid, req0_rdata, pat(10'h010)); end
    tick();
    idle();
    @(negedge clk);
    checks++; if ({req1_rvalid, req1_rdata} !== {1'b1, pat(10'h020)}) begin
      errors++; $display("FAIL b2b_rsp1 got v=%b d=%h exp v=1 d=%h", req1_rvalid, req1_rdata, pat(10'h020)); end
    checks++; if ({req0_rvalid, req0_rdata} !== {1'b0, 32'h0}) begin
      errors++; $display("FAIL b2b_other got v=%b d=%h exp v=0 d=0", req0_rvalid, req0_rdata); end
    tick();
  endtask

  task automatic test_reset_mid_read();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 10'h007, '0);
    @(negedge clk);
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL rmid_accept got=%b exp=1", req1_ready); end
    tick();
    reset = 1'b1;
    idle();
    @(negedge clk);
    checks++; if ({req0_rvalid, req1_rvalid, req1_rdata} !== {2'b00, 32'h0}) begin
      errors++; $display("FAIL rmid_t1 got v=%b%b d=%h exp 00 0", req0_rvalid, req1_rvalid, req1_rdata); end
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++; if ({req0_rvalid, req1_rvalid} !== 2'b00) begin
      errors++; $display("FAIL rmid_t2 got=%b exp=00", {req0_rvalid, req1_rvalid}); end
    tick();
    drive(1'b1, 1'b0, 10'h001, '0, 1'b1, 1'b0, 10'h002, '0);
    @(negedge clk);
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL rmid_ptr got r0r1=%b exp=10", {req0_ready, req1_ready}); end
    tick();
    idle();
    tick();
  endtask

  task automatic test_idle();
    drive(1'b1, 1'b1, 10'h030, 32'h1234, 1'b0, 1'b0, '0, '0);
    tick();
    idle();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if ({mem_en, mem_we, req0_ready, req1_ready} !== 4'b0000) begin
        errors++; $display("FAIL idle[%0d] got en=%b we=%b r0=%b r1=%b exp 0000", k, mem_en, mem_we, req0_ready, req1_ready); end
      tick();
    end
    // Last grant went to port 0 before the idle gap, so round-robin must now favour port 1.
    drive(1'b1, 1'b0, 10'h001, '0, 1'b1, 1'b0, 10'h002, '0);
    @(negedge clk);
`ifdef DMEM_ARB_FIXED_PRIO_EN
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL idle_ptr got r0r1=%b exp=10", {req0_ready, req1_ready}); end
`else
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin
      errors++; $display("FAIL idle_ptr got r0r1=%b exp=01", {req0_ready, req1_ready}); end
`endif
    tick();
    idle();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #1;
    test_reset();
    test_single_read();
    test_contention();
    test_write_read();
    test_back_to_back();
    test_reset_mid_read();
    test_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares one synchronous single-port data RAM between two requesters.
- Port 0 is the core load/store port; port 1 is a DMA/program-loader port.
- Arbitrates per cycle using round-robin, or fixed priority when the optional feature is compiled in.
- Drives the RAM and routes read data back to the winning requester one cycle later, tagged by owner.

Parameters:
- AW, 10: word-address width; RAM depth is 2^AW words.
- DW, 32: data width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  core request valid.
- req0_we  in  1  core write (1) / read (0).
- req0_addr  in  AW  core word address.
- req0_wdata  in  DW  core write data.
- req0_ready  out  1  core request accepted this cycle.
- req0_rvalid  out  1  core read data valid.
- req0_rdata  out  DW  core read data.
- req1_valid, req1_we, req1_addr, req1_wdata, req1_ready, req1_rvalid, req1_rdata: same as port 0, for the DMA/loader.
- mem_en  out  1  RAM access enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data, valid the cycle after a read is issued.

Behaviour:
- **Reset values:** reset=1 clears rr_ptr to 0 (port 0 preferred next), rsp_pending=0, rsp_owner=0. All rvalid=0. All outputs are 0 while reset is high, including ready and mem_en. Reset mid-read drops the in-flight response: no rvalid the cycle after reset deasserts.
- **Grant (combinational):**
  - Only 0 valid: grant 0. Only 1 valid: grant 1.
  - Both valid: grant port rr_ptr.
  - Neither valid: no grant; mem_en=0.
- **Issue:**
  - reqN_ready = grantN.
  - mem_en=1, and mem_we/mem_addr/mem_wdata are muxed from the granted port in the same cycle.
  - Handshake completes when valid && ready.
- **Requester rules:** valid must not depend on ready. Valid, addr, we and wdata stay stable until ready. The arbiter does not buffer requests.
- **Round-robin update:** on any grant, rr_ptr <= ~granted_port. With no grant, rr_ptr holds.
- **Read response:**
  - Latency is exactly 1 cycle after the accept cycle.
  - Accepting a read sets rsp_pending=1 and rsp_owner=port.
  - Next cycle: reqN_rvalid=1 for N=rsp_owner, and reqN_rdata=mem_rdata. The other port's rdata is 0.
  - rvalid is a single-cycle pulse; there is no rready and the requester must sample.
- **Writes:** complete at accept. No rvalid.
- **Throughput:** one access per cycle. Back-to-back reads from either port, or alternating ports, are fully pipelined: a new issue and the previous response coexist in the same cycle.
- **Same-address hazard:** a write accepted in cycle t followed by a read of the same address in t+1 returns the new data. This relies on RAM write-first ordering across cycles; no arbiter forwarding is needed.
- **Stall:** a requester not granted sees ready=0 and holds its request. Under round-robin, a requester never waits more than 1 cycle while the other is continuously valid.

Optional Feature:
- Macro: DMEM_ARB_FIXED_PRIO_EN.
- **Defined:** port 0 always wins when both are valid. rr_ptr logic is removed. Port 1 may starve while port 0 is continuously valid.
- **Undefined:** round-robin as above.

Test Plan:
- **Single read:** after reset, req0 read addr 0x005 with RAM[5]=0xDEADBEEF → req0_ready=1 at t. At t+1, req0_rvalid=1 and req0_rdata=0xDEADBEEF; req1_rvalid=0.
- **Contention:** both valid reads (0x001, 0x002) held for 4 cycles.
  - Round-robin build: grants 0,1,0,1, with rvalid alternating correctly one cycle later.
  - DMEM_ARB_FIXED_PRIO_EN build: grants 0,0,0,0; req1_ready stays 0.
- **Write then read:** req1 writes 0x0000_00AA to 0x3FF, then reads it the next cycle → req1_rdata=0x0000_00AA. No rvalid after the write.
- **Back-to-back mixed:** req0 reads 0x010, req1 reads 0x020 in consecutive cycles → each rvalid arrives on the correct port with the correct data, and mem_en=1 both cycles.
- **Reset mid-read:** read accepted at t, reset=1 at t+1 → all rvalid=0 at t+1 and t+2; rr_ptr=0 afterwards.
- **Idle:** neither valid → mem_en=0, mem_we=0, both ready=0, rr_ptr unchanged.
